collision_scorer: RTL and testbench
===================================

Name: collision_scorer

Overview:
- Game-logic stage between the position producers (ship, bullet, eight asteroid blocks) and the asteroid hit inputs and HEX score display.
- On each frame tick it scans all asteroids against the bullet and the ship, using one-hot coordinate buses.
- Raises per-asteroid hit flags, a sticky ship-dead flag and a 4-digit BCD score.
- Replaces the per-asteroid hit checkers left unimplemented at top level.

Parameters:
- SCREEN_W, 160, width of the one-hot x buses.
- SCREEN_H, 120, width of the one-hot y buses.
- N_AST, 8, number of asteroids scanned.
- HIT_RADIUS, 1, bullet-vs-asteroid hit window per axis (3x3 asteroid).
- SHIP_RADIUS, 2, ship-vs-asteroid hit window per axis (3x3 ship + 3x3 asteroid).

Ports:
- clock  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  asynchronous, active-high reset (top level drives ~resetn).
- tick  in  1  one-cycle frame strobe in the clock domain (start scan).
- bullet_x  in  SCREEN_W  one-hot bullet column; all-zero = no bullet.
- bullet_y  in  SCREEN_H  one-hot bullet row.
- ship_x  in  SCREEN_W  one-hot ship centre column.
- ship_y  in  SCREEN_H  one-hot ship centre row.
- ast_x  in  N_AST*SCREEN_W  packed one-hot asteroid centre columns; asteroid i at [i*SCREEN_W +: SCREEN_W].
- ast_y  in  N_AST*SCREEN_H  packed one-hot asteroid centre rows, same packing.
- hit  out  N_AST  per-asteroid hit flags from the last completed scan.
- bullet_consumed  out  1  one-cycle pulse at scan end if any asteroid was hit by the bullet.
- ship_dead  out  1  sticky ship/asteroid collision flag.
- score_bcd  out  16  four BCD digits, [15:12] most significant.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a scan finishes.

Behaviour:
- Reset is asynchronous, active-high and may arrive at any time, including mid-scan. It forces the FSM to IDLE and clears:
  - hit = 0, bullet_consumed = 0, ship_dead = 0, score_bcd = 16'h0000, busy = 0, done = 0;
  - the internal index and the scratch hit vector.
- Single clock domain; tick is sampled on the rising clock edge.
- One-hot decode (sub-module): returns the 8-bit index of the lowest set bit plus a valid bit.
  - All-zero bus gives valid = 0.
  - A bus with several bits set decodes to the lowest index.
- FSM states: IDLE, LOAD, SCAN, DONE.
  - IDLE: busy = 0. tick = 1 moves to LOAD.
  - LOAD: registers the decoded bullet (bx, by, bvalid) and ship (sx, sy, svalid). Clears the scratch vector and sets idx = 0. Moves to SCAN.
  - SCAN: one asteroid per cycle for idx = 0..N_AST-1, decoded combinationally from the packed bus. For a valid asteroid:
    - bullet hit when bvalid and |ax-bx| <= HIT_RADIUS and |ay-by| <= HIT_RADIUS; sets scratch[idx]. Unless ship_dead = 1, score also increments by 1 in that cycle.
    - ship hit when svalid and |ax-sx| <= SHIP_RADIUS and |ay-sy| <= SHIP_RADIUS; sets ship_dead.
    - An asteroid with invalid x or y never hits.
    - After idx = N_AST-1, go to DONE.
  - DONE: hit <= scratch. done = 1 for this cycle. bullet_consumed = |scratch for this cycle. Return to IDLE.
- Timing: tick at cycle 0 gives LOAD at 1, SCAN at 2..N_AST+1, and DONE/hit update at N_AST+2 (cycle 10 with defaults).
- busy is high from LOAD through DONE. A tick while busy is ignored; it is neither queued nor counted.
- hit holds its value between scans. A bullet hitting several asteroids in one scan flags all of them and adds one point each.
- Absolute differences are computed on 9-bit signed values, so no wrap occurs at screen edges.
- Score counter:
  - BCD with decimal carry: digit 9 becomes 0 and carries into the next digit.
  - Saturates at 9999; further hits leave it at 16'h9999.
- ship_dead is sticky until reset. While it is set, hits are still flagged but the score is frozen.

Decomposition:
- Shared package holds SCREEN_W/SCREEN_H constants, the FSM state encoding (IDLE = 0, LOAD = 1, SCAN = 2, DONE = 3) and the BCD digit max (4'd9).
- One sub-module: onehot_index, a parameterised WIDTH one-hot (lowest-bit priority) to index converter with a valid output. It is instantiated for bullet, ship and the current asteroid.

Test Plan:
- Reset, then idle with no tick → all outputs zero. Assert reset mid-SCAN → FSM back to IDLE next edge, busy = 0, score 0000, hit 0.
- Bullet at (50,40), asteroid 3 at (50,40), others at (10,10), ship at (80,60); tick → busy for cycles 1..10, done at cycle 10, hit = 8'b00001000, bullet_consumed pulse, score_bcd = 16'h0001.
- Bullet at (52,40), asteroid 3 at (50,40) → hit = 0, score unchanged. Bullet at (51,41) → hit[3] = 1. Bullet bus all-zero → no hits.
- Ship at (80,60), asteroid 0 at (82,58) → ship_dead = 1 after scan. Then a bullet hit → hit flag set, score frozen. ship_dead stays 1 until reset.
- Score preset to 0009 via 9 hit scans; next hit → 0010. Drive up to 9999; one more hit → stays 9999.
- Second tick at cycle 4 of a scan → ignored, a single done pulse only. Asteroid bus with bits 20 and 30 set → decoded x = 20.

Source files
------------

// File: rtl/collision_scorer_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the collision scorer.
package collision_scorer_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int N_AST    = 8;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Four-digit BCD increment with decimal carry; holds at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int unsigned d = 0; d < 4; d++) begin
                if (carry) begin
                    if (r[d*4 +: 4] == BCD_MAX) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // |a - b| <= r, evaluated on 9-bit signed values so screen edges never wrap.
    function automatic logic within_radius(input logic [7:0] a, input logic [7:0] b, input int r);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d < 0) d = -d;
        return (int'(d) <= r);
    endfunction

endpackage

// File: rtl/collision_scorer_if.sv
// Position buses in, hit/score/status out, grouped for the collision scorer.
interface collision_scorer_if #(
    parameter int SCREEN_W = collision_scorer_pkg::SCREEN_W,
    parameter int SCREEN_H = collision_scorer_pkg::SCREEN_H,
    parameter int N_AST    = collision_scorer_pkg::N_AST
);
    logic                        tick;
    logic [SCREEN_W-1:0]         bullet_x;
    logic [SCREEN_H-1:0]         bullet_y;
    logic [SCREEN_W-1:0]         ship_x;
    logic [SCREEN_H-1:0]         ship_y;
    logic [N_AST*SCREEN_W-1:0]   ast_x;
    logic [N_AST*SCREEN_H-1:0]   ast_y;
    logic [N_AST-1:0]            hit;
    logic                        bullet_consumed;
    logic                        ship_dead;
    logic [15:0]                 score_bcd;
    logic                        busy;
    logic                        done;

    modport master (
        output tick, bullet_x, bullet_y, ship_x, ship_y, ast_x, ast_y,
        input  hit, bullet_consumed, ship_dead, score_bcd, busy, done
    );

    modport slave (
        input  tick, bullet_x, bullet_y, ship_x, ship_y, ast_x, ast_y,
        output hit, bullet_consumed, ship_dead, score_bcd, busy, done
    );
endinterface

// File: rtl/collision_scorer_onehot_index.sv
// One-hot to index converter; lowest set bit wins, all-zero gives valid = 0.
module onehot_index #(
    parameter int WIDTH = 160
) (
    input  logic [WIDTH-1:0] bus,
    output logic [7:0]       index,
    output logic             valid
);
    // Scan upward and keep the first set bit found.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus[i] && !valid) begin
                index = 8'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/collision_scorer.sv
// Per-frame asteroid scan against bullet and ship: hit flags, sticky ship_dead, BCD score.
module collision_scorer #(
    parameter int SCREEN_W    = collision_scorer_pkg::SCREEN_W,
    parameter int SCREEN_H    = collision_scorer_pkg::SCREEN_H,
    parameter int N_AST       = collision_scorer_pkg::N_AST,
    parameter int HIT_RADIUS  = 1,
    parameter int SHIP_RADIUS = 2
) (
    input  logic               clock,
    input  logic               reset,
    collision_scorer_if.slave  io
);
    import collision_scorer_pkg::*;

    localparam int IDX_W = (N_AST > 1) ? $clog2(N_AST) : 1;

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         bx, by, sx, sy;
    logic               bvalid, svalid;
    logic [N_AST-1:0]   scratch, scratch_next;
    logic [N_AST-1:0]   hit_q;
    logic               ship_dead_q;
    logic [15:0]        score;

    logic [7:0]         dbx, dby, dsx, dsy, dax, day;
    logic               vbx, vby, vsx, vsy, vax, vay;
    logic [SCREEN_W-1:0] cur_ax;
    logic [SCREEN_H-1:0] cur_ay;
    logic               last, bullet_hit, ship_hit;

    assign cur_ax = io.ast_x[idx*SCREEN_W +: SCREEN_W];
    assign cur_ay = io.ast_y[idx*SCREEN_H +: SCREEN_H];

    onehot_index #(.WIDTH(SCREEN_W)) u_bx (.bus(io.bullet_x), .index(dbx), .valid(vbx));
    onehot_index #(.WIDTH(SCREEN_H)) u_by (.bus(io.bullet_y), .index(dby), .valid(vby));
    onehot_index #(.WIDTH(SCREEN_W)) u_sx (.bus(io.ship_x),   .index(dsx), .valid(vsx));
    onehot_index #(.WIDTH(SCREEN_H)) u_sy (.bus(io.ship_y),   .index(dsy), .valid(vsy));
    onehot_index #(.WIDTH(SCREEN_W)) u_ax (.bus(cur_ax),      .index(dax), .valid(vax));
    onehot_index #(.WIDTH(SCREEN_H)) u_ay (.bus(cur_ay),      .index(day), .valid(vay));

    assign last = (idx == IDX_W'(N_AST - 1));

    // Collision tests for the asteroid currently selected by idx.
    always_comb begin
        bullet_hit = 1'b0;
        ship_hit   = 1'b0;
        if (state == SCAN && vax && vay) begin
            bullet_hit = bvalid && within_radius(dax, bx, HIT_RADIUS)
                                && within_radius(day, by, HIT_RADIUS);
            ship_hit   = svalid && within_radius(dax, sx, SHIP_RADIUS)
                                && within_radius(day, sy, SHIP_RADIUS);
        end
    end

    // Scratch vector including the current asteroid's bullet hit.
    always_comb begin
        scratch_next = scratch;
        if (bullet_hit) scratch_next[idx] = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic; ticks outside IDLE are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (io.tick) state_next = LOAD;
            LOAD:    state_next = SCAN;
            SCAN:    if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scan datapath: latch positions, step index, accumulate hits, score and ship_dead.
    // hit is written on the final SCAN edge so it is already valid while done is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx         <= '0;
            bx          <= '0;
            by          <= '0;
            sx          <= '0;
            sy          <= '0;
            bvalid      <= 1'b0;
            svalid      <= 1'b0;
            scratch     <= '0;
            hit_q       <= '0;
            ship_dead_q <= 1'b0;
            score       <= '0;
        end else begin
            case (state)
                LOAD: begin
                    bx      <= dbx;
                    by      <= dby;
                    bvalid  <= vbx && vby;
                    sx      <= dsx;
                    sy      <= dsy;
                    svalid  <= vsx && vsy;
                    scratch <= '0;
                    idx     <= '0;
                end
                SCAN: begin
                    scratch <= scratch_next;
                    if (bullet_hit && !ship_dead_q) score <= bcd_inc(score);
                    if (ship_hit) ship_dead_q <= 1'b1;
                    if (last) hit_q <= scratch_next;
                    else      idx   <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io.hit             = hit_q;
    assign io.ship_dead       = ship_dead_q;
    assign io.score_bcd       = score;
    assign io.busy            = (state != IDLE);
    assign io.done            = (state == DONE);
    assign io.bullet_consumed = (state == DONE) && (|scratch);

endmodule

// File: tb/tb_collision_scorer.sv
// Directed scoreboard bench for collision_scorer.
module tb_collision_scorer;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    collision_scorer_if #(.SCREEN_W(W), .SCREEN_H(H), .N_AST(N)) bus ();

    collision_scorer #(
        .SCREEN_W(W), .SCREEN_H(H), .N_AST(N), .HIT_RADIUS(1), .SHIP_RADIUS(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io(bus)
    );

    typedef struct {
        logic [N-1:0] hit;
        logic         consumed;
        logic [15:0]  score;
        logic         dead;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: coordinates (-1 = absent), score as integer, sticky dead flag.
    int axm[N];
    int aym[N];
    int bxm, bym, sxm, sym;
    int score_m;
    bit dead_m;
    int extra_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic drive_bus();
        bus.bullet_x = '0;
        bus.bullet_y = '0;
        bus.ship_x   = '0;
        bus.ship_y   = '0;
        bus.ast_x    = '0;
        bus.ast_y    = '0;
        if (bxm >= 0) bus.bullet_x[bxm] = 1'b1;
        if (bym >= 0) bus.bullet_y[bym] = 1'b1;
        if (sxm >= 0) bus.ship_x[sxm] = 1'b1;
        if (sym >= 0) bus.ship_y[sym] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (axm[i] >= 0) bus.ast_x[i*W + axm[i]] = 1'b1;
            if (aym[i] >= 0) bus.ast_y[i*H + aym[i]] = 1'b1;
        end
        if (extra_bit >= 0) bus.ast_x[extra_bit] = 1'b1;
    endtask

    task automatic model_scan(output exp_t e);
        logic [N-1:0] h;
        bit bv, sv;
        h  = '0;
        bv = (bxm >= 0) && (bym >= 0);
        sv = (sxm >= 0) && (sym >= 0);
        for (int i = 0; i < N; i++) begin
            if (axm[i] >= 0 && aym[i] >= 0) begin
                if (bv && iabs(axm[i] - bxm) <= 1 && iabs(aym[i] - bym) <= 1) begin
                    h[i] = 1'b1;
                    if (!dead_m && score_m < 9999) score_m++;
                end
                if (sv && iabs(axm[i] - sxm) <= 2 && iabs(aym[i] - sym) <= 2) dead_m = 1'b1;
            end
        end
        e.hit      = h;
        e.consumed = |h;
        e.score    = to_bcd(score_m);
        e.dead     = dead_m;
    endtask

    task automatic run_scan(input bit extra_tick);
        exp_t e;
        exp_t got;
        int   cyc;
        int   idle;
        int   dcount;
        drive_bus();
        model_scan(e);
        sb.push_back(e);
        @(negedge clock);
        bus.tick = 1'b1;
        @(negedge clock);
        bus.tick = 1'b0;
        cyc  = 1;
        idle = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy !== 1'b1) idle++;
            @(negedge clock);
            cyc++;
            bus.tick = extra_tick && (cyc == 4);
        end
        bus.tick = 1'b0;
        check("done_latency", cyc, N + 2);
        check("busy_during_scan_drops", idle, 0);
        check("busy_at_done", bus.busy, 1'b1);
        got = sb.pop_front();
        check("hit", bus.hit, got.hit);
        check("bullet_consumed", bus.bullet_consumed, got.consumed);
        check("score_bcd", bus.score_bcd, got.score);
        check("ship_dead", bus.ship_dead, got.dead);
        @(negedge clock);
        check("done_one_cycle", bus.done, 1'b0);
        check("consumed_one_cycle", bus.bullet_consumed, 1'b0);
        check("busy_after_done", bus.busy, 1'b0);
        check("hit_held", bus.hit, got.hit);
        if (extra_tick) begin
            dcount = 0;
            repeat (15) begin
                @(negedge clock);
                if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
            end
            check("extra_tick_ignored", dcount, 0);
        end
    endtask

    task automatic default_positions();
        for (int i = 0; i < N; i++) begin
            axm[i] = 10;
            aym[i] = 10;
        end
        axm[3] = 50;
        aym[3] = 40;
        bxm = 50;
        bym = 40;
        sxm = 80;
        sym = 60;
        extra_bit = -1;
    endtask

    initial begin
        reset    = 1'b1;
        bus.tick = 1'b0;
        score_m  = 0;
        dead_m   = 1'b0;
        default_positions();
        drive_bus();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_hit", bus.hit, '0);
        check("reset_score", bus.score_bcd, 16'h0000);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_dead", bus.ship_dead, 1'b0);
        check("reset_consumed", bus.bullet_consumed, 1'b0);

        // Basic hit on asteroid 3.
        run_scan(1'b0);

        // Reset in the middle of a scan.
        @(negedge clock);
        bus.tick = 1'b1;
        @(negedge clock);
        bus.tick = 1'b0;
        repeat (3) @(negedge clock);
        check("busy_before_midreset", bus.busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midreset_busy", bus.busy, 1'b0);
        check("midreset_hit", bus.hit, '0);
        check("midreset_score", bus.score_bcd, 16'h0000);
        check("midreset_done", bus.done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        score_m = 0;
        dead_m  = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_after_midreset", bus.busy, 1'b0);

        run_scan(1'b0);                      // hit again -> 0001
        bxm = 52; run_scan(1'b0);            // out of radius
        bxm = 51; bym = 41; run_scan(1'b0);  // diagonal edge of window
        bxm = -1; bym = -1; run_scan(1'b0);  // no bullet

        // Multi-bit asteroid x bus: bits 20 and 30 decode to 20.
        axm[3] = 20;
        extra_bit = 3*W + 30;
        bxm = 20; bym = 40; run_scan(1'b0);
        bxm = 30; run_scan(1'b0);
        default_positions();

        // Climb to 0009 then carry into 0010.
        while (score_m < 9) run_scan(1'b0);
        run_scan(1'b0);
        check("score_carry_0010", bus.score_bcd, 16'h0010);

        // Tick arriving mid-scan is ignored.
        run_scan(1'b1);

        // One bullet hitting three asteroids.
        axm[5] = 49; aym[5] = 39;
        axm[6] = 51; aym[6] = 41;
        run_scan(1'b0);
        default_positions();

        // Ship collision at idx 0 freezes score for the bullet hit later in the same scan.
        axm[0] = 82; aym[0] = 58;
        run_scan(1'b0);
        axm[0] = 10; aym[0] = 10;
        run_scan(1'b0);
        run_scan(1'b0);

        // Reset, then drive to saturation with eight hits per scan.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        score_m = 0;
        dead_m  = 1'b0;
        check("dead_cleared", bus.ship_dead, 1'b0);
        for (int i = 0; i < N; i++) begin
            axm[i] = 50;
            aym[i] = 40;
        end
        sxm = -1;
        sym = -1;
        while (score_m < 9999) run_scan(1'b0);
        check("score_9999", bus.score_bcd, 16'h9999);
        run_scan(1'b0);
        check("score_saturated", bus.score_bcd, 16'h9999);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
